// File: rtl/rv32i_dbg_reg_access_if.sv
// Debug transport channels: command (valid/ready) and response (valid/ready)
// between the debug transport (master) and the register access controller (slave).
interface rv32i_dbg_reg_access_if #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic                      cmd_write;
  logic [REG_ADDR_WIDTH-1:0] cmd_addr;
  logic [XLEN-1:0]           cmd_wdata;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [XLEN-1:0]           rsp_rdata;
  logic [1:0]                rsp_err;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/rv32i_dbg_reg_access.sv
// Debug-side register file access controller: halt wait, write collision retry, one response per command.
// Optional readback check of every debug write is enabled by defining DBG_READBACK_VERIFY_EN.
module rv32i_dbg_reg_access #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int HALT_TIMEOUT   = 16,
  parameter int MAX_RETRY      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  rv32i_dbg_reg_access_if.slave     bus,
  input  logic                      cpu_halted,
  input  logic                      rd_we_snoop,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_snoop,
  output logic [REG_ADDR_WIDTH-1:0] dbg_addr,
  output logic [XLEN-1:0]           dbg_wdata,
  output logic                      dbg_we,
  input  logic [XLEN-1:0]           dbg_rdata
);
  localparam int TW = $clog2(HALT_TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_RETRY    = 2'b10;
`ifdef DBG_READBACK_VERIFY_EN
  localparam logic [1:0] ERR_MISMATCH = 2'b11;
`endif

`ifdef DBG_READBACK_VERIFY_EN
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_HALT = 3'd1,
    ACCESS    = 3'd2,
    VERIFY    = 3'd3,
    RESP      = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_HALT = 3'd1,
    ACCESS    = 3'd2,
    RESP      = 3'd4
  } state_t;
`endif

  state_t                    state_r, state_s;
  logic                      write_r, write_s;
  logic [REG_ADDR_WIDTH-1:0] addr_r, addr_s;
  logic [XLEN-1:0]           wdata_r, wdata_s;
  logic [XLEN-1:0]           rdata_r, rdata_s;
  logic [1:0]                err_r, err_s;
  logic                      valid_r, valid_s;
  logic [TW-1:0]             tcnt_r, tcnt_s;
  logic [RW-1:0]             rcnt_r, rcnt_s;
  logic                      we_s;
  logic                      collision_s;
  logic                      addr_zero_s;

  assign collision_s   = rd_we_snoop && (rd_addr_snoop == addr_r);
  assign addr_zero_s   = (addr_r == {REG_ADDR_WIDTH{1'b0}});

  assign bus.cmd_ready = (state_r == IDLE) && !rst;
  assign bus.rsp_valid = valid_r;
  assign bus.rsp_rdata = rdata_r;
  assign bus.rsp_err   = err_r;
  assign dbg_addr      = addr_r;
  assign dbg_wdata     = wdata_r;
  assign dbg_we        = we_s;

  // Next-state and next-output computation for the access sequencer
  always_comb begin
    state_s = state_r;
    write_s = write_r;
    addr_s  = addr_r;
    wdata_s = wdata_r;
    rdata_s = rdata_r;
    err_s   = err_r;
    valid_s = valid_r;
    tcnt_s  = tcnt_r;
    rcnt_s  = rcnt_r;
    we_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.cmd_valid) begin
          write_s = bus.cmd_write;
          addr_s  = bus.cmd_addr;
          wdata_s = bus.cmd_wdata;
          tcnt_s  = {TW{1'b0}};
          rcnt_s  = {RW{1'b0}};
          state_s = WAIT_HALT;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT_HALT: begin
        if (cpu_halted) begin
          state_s = ACCESS;
        end else begin
          tcnt_s = tcnt_r + TW'(1);
          if (tcnt_s == TW'(HALT_TIMEOUT)) begin
            rdata_s = {XLEN{1'b0}};
            err_s   = ERR_TIMEOUT;
            valid_s = 1'b1;
            state_s = RESP;
          end else begin
            state_s = WAIT_HALT;
          end
        end
      end
      ACCESS: begin
        if (!write_r || addr_zero_s) begin
          // x0 always reads as zero and silently drops writes
          rdata_s = (write_r || addr_zero_s) ? {XLEN{1'b0}} : dbg_rdata;
          err_s   = ERR_OK;
          valid_s = 1'b1;
          state_s = RESP;
        end else begin
          we_s    = 1'b1;
          rdata_s = {XLEN{1'b0}};
          if (collision_s) begin
            rcnt_s = rcnt_r + RW'(1);
            if (rcnt_s == RW'(MAX_RETRY)) begin
              err_s   = ERR_RETRY;
              valid_s = 1'b1;
              state_s = RESP;
            end else begin
              state_s = ACCESS;
            end
          end else begin
`ifdef DBG_READBACK_VERIFY_EN
            state_s = VERIFY;
`else
            err_s   = ERR_OK;
            valid_s = 1'b1;
            state_s = RESP;
`endif
          end
        end
      end
`ifdef DBG_READBACK_VERIFY_EN
      VERIFY: begin
        err_s   = (dbg_rdata == wdata_r) ? ERR_OK : ERR_MISMATCH;
        valid_s = 1'b1;
        state_s = RESP;
      end
`endif
      RESP: begin
        if (bus.rsp_ready) begin
          valid_s = 1'b0;
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        valid_s = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State and registered-output update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      write_r <= 1'b0;
      addr_r  <= {REG_ADDR_WIDTH{1'b0}};
      wdata_r <= {XLEN{1'b0}};
      rdata_r <= {XLEN{1'b0}};
      err_r   <= 2'b00;
      valid_r <= 1'b0;
      tcnt_r  <= {TW{1'b0}};
      rcnt_r  <= {RW{1'b0}};
    end else begin
      state_r <= state_s;
      write_r <= write_s;
      addr_r  <= addr_s;
      wdata_r <= wdata_s;
      rdata_r <= rdata_s;
      err_r   <= err_s;
      valid_r <= valid_s;
      tcnt_r  <= tcnt_s;
      rcnt_r  <= rcnt_s;
    end
  end
endmodule

// File: tb/tb_rv32i_dbg_reg_access.sv
// Directed self-checking bench for rv32i_dbg_reg_access with a behavioural two-port regfile model.
module tb_rv32i_dbg_reg_access;
  localparam logic [31:0] RD_PORT_DATA = 32'h1111_1111;
`ifdef DBG_READBACK_VERIFY_EN
  localparam int WR_LAT = 4;
`else
  localparam int WR_LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_halted;
  logic        rd_we_snoop;
  logic [4:0]  rd_addr_snoop;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_we;
  logic [31:0] dbg_rdata;
  logic [31:0] regs [32] = '{default: 32'h0};

  int tests_run    = 0;
  int tests_failed = 0;

  rv32i_dbg_reg_access_if #(.XLEN(32), .REG_ADDR_WIDTH(5)) bus ();

  rv32i_dbg_reg_access #(
    .XLEN(32), .REG_ADDR_WIDTH(5), .HALT_TIMEOUT(16), .MAX_RETRY(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .cpu_halted    (cpu_halted),
    .rd_we_snoop   (rd_we_snoop),
    .rd_addr_snoop (rd_addr_snoop),
    .dbg_addr      (dbg_addr),
    .dbg_wdata     (dbg_wdata),
    .dbg_we        (dbg_we),
    .dbg_rdata     (dbg_rdata)
  );

  always #5 clk = ~clk;

  // Regfile: the rd port wins a same-register collision; x9 debug writes are corrupted when verify is built in
  assign dbg_rdata = (dbg_addr == 5'd0) ? 32'h0 : regs[dbg_addr];
  always @(posedge clk) begin
    if (rd_we_snoop && rd_addr_snoop != 5'd0) regs[rd_addr_snoop] <= RD_PORT_DATA;
    if (dbg_we && dbg_addr != 5'd0 && !(rd_we_snoop && rd_addr_snoop == dbg_addr))
`ifdef DBG_READBACK_VERIFY_EN
      regs[dbg_addr] <= (dbg_addr == 5'd9) ? (dbg_wdata ^ 32'h1) : dbg_wdata;
`else
      regs[dbg_addr] <= dbg_wdata;
`endif
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one command at cycle T and returns when rsp_valid is seen; lat counts cycles from T.
  task automatic run_cmd(input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                         input logic halted, input int coll,
                         output logic [31:0] rdata, output logic [1:0] err,
                         output int lat, output int we_cnt, output logic addr_bad);
    bit done = 1'b0;
    we_cnt   = 0;
    lat      = 0;
    addr_bad = 1'b0;
    rdata    = 32'h0;
    err      = 2'b00;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    cpu_halted    = halted;
    #0;
    check_eq("cmd_ready_idle", {31'h0, bus.cmd_ready}, 32'd1);
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      rd_we_snoop   = (cyc >= 2 && cyc < 2 + coll);
      rd_addr_snoop = rd_we_snoop ? addr : 5'd0;
      if (dbg_we) begin
        we_cnt++;
        if (dbg_addr != addr) addr_bad = 1'b1;
      end
      if (bus.rsp_valid) begin
        done  = 1'b1;
        lat   = cyc;
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
      end else begin
        tick();
        bus.cmd_valid = 1'b0;
      end
    end
    rd_we_snoop   = 1'b0;
    rd_addr_snoop = 5'd0;
    if (!done) check_eq("rsp_valid_wait_expired", 32'd0, 32'd1);
  endtask

  // Holds rsp_ready low for hold cycles, then completes the handshake.
  task automatic finish_rsp(input int hold, input logic [31:0] exp_rdata, input logic [1:0] exp_err);
    for (int i = 0; i < hold; i++) begin
      tick();
      check_eq("stall_rsp_valid", {31'h0, bus.rsp_valid}, 32'd1);
      check_eq("stall_rsp_rdata", bus.rsp_rdata, exp_rdata);
      check_eq("stall_rsp_err", {30'h0, bus.rsp_err}, {30'h0, exp_err});
      check_eq("stall_cmd_ready", {31'h0, bus.cmd_ready}, 32'd0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    #0;
    check_eq("rsp_valid_drop", {31'h0, bus.rsp_valid}, 32'd0);
    check_eq("cmd_ready_after_rsp", {31'h0, bus.cmd_ready}, 32'd1);
  endtask

  task automatic do_cmd(input string tag, input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                        input logic halted, input int coll, input int hold,
                        input logic [31:0] exp_rdata, input logic [1:0] exp_err,
                        input int exp_lat, input int exp_we);
    logic [31:0] rdata;
    logic [1:0]  err;
    int          lat;
    int          we_cnt;
    logic        addr_bad;
    run_cmd(wr, addr, wdata, halted, coll, rdata, err, lat, we_cnt, addr_bad);
    check_eq({tag, "_rdata"}, rdata, exp_rdata);
    check_eq({tag, "_err"}, {30'h0, err}, {30'h0, exp_err});
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_we_cycles"}, 32'(we_cnt), 32'(exp_we));
    check_eq({tag, "_we_addr_bad"}, {31'h0, addr_bad}, 32'd0);
    finish_rsp(hold, exp_rdata, exp_err);
  endtask

  initial begin
    int seen_valid;
    int seen_we;
    rst           = 1'b1;
    cpu_halted    = 1'b0;
    rd_we_snoop   = 1'b0;
    rd_addr_snoop = 5'd0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 5'd0;
    bus.cmd_wdata = 32'h0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    check_eq("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'd0);
    check_eq("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check_eq("rst_rsp_err", {30'h0, bus.rsp_err}, 32'd0);
    check_eq("rst_dbg_we", {31'h0, dbg_we}, 32'd0);
    check_eq("rst_dbg_addr", {27'h0, dbg_addr}, 32'd0);
    check_eq("rst_dbg_wdata", dbg_wdata, 32'h0);
    check_eq("rst_cmd_ready", {31'h0, bus.cmd_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check_eq("cmd_ready_post_rst", {31'h0, bus.cmd_ready}, 32'd1);

    do_cmd("wr_x5", 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 0, 0, 32'h0, 2'b00, WR_LAT, 1);
    do_cmd("rd_x5", 1'b0, 5'd5, 32'h0, 1'b1, 0, 0, 32'hDEAD_BEEF, 2'b00, 3, 0);
    do_cmd("wr_timeout", 1'b1, 5'd6, 32'h1234_5678, 1'b0, 0, 0, 32'h0, 2'b01, 17, 0);
    do_cmd("rd_x6", 1'b0, 5'd6, 32'h0, 1'b1, 0, 0, 32'h0, 2'b00, 3, 0);
    do_cmd("wr_x7_coll2", 1'b1, 5'd7, 32'hCAFE_BABE, 1'b1, 2, 0, 32'h0, 2'b00, WR_LAT + 2, 3);
    do_cmd("rd_x7", 1'b0, 5'd7, 32'h0, 1'b1, 0, 0, 32'hCAFE_BABE, 2'b00, 3, 0);
    do_cmd("wr_x7_coll4", 1'b1, 5'd7, 32'h0BAD_F00D, 1'b1, 4, 0, 32'h0, 2'b10, 6, 4);
    do_cmd("rd_x7_rdport", 1'b0, 5'd7, 32'h0, 1'b1, 0, 0, RD_PORT_DATA, 2'b00, 3, 0);
    do_cmd("wr_x0", 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 0, 0, 32'h0, 2'b00, 3, 0);
    do_cmd("rd_x0", 1'b0, 5'd0, 32'h0, 1'b1, 0, 0, 32'h0, 2'b00, 3, 0);
    do_cmd("rd_x5_stall", 1'b0, 5'd5, 32'h0, 1'b1, 0, 5, 32'hDEAD_BEEF, 2'b00, 3, 0);
`ifdef DBG_READBACK_VERIFY_EN
    do_cmd("wr_x9_verify", 1'b1, 5'd9, 32'h0000_00F0, 1'b1, 0, 0, 32'h0, 2'b11, 4, 1);
`else
    do_cmd("wr_x9", 1'b1, 5'd9, 32'h0000_00F0, 1'b1, 0, 0, 32'h0, 2'b00, 3, 1);
`endif

    // Reset while waiting for halt: command is dropped and never answered
    cpu_halted    = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 5'd5;
    bus.cmd_wdata = 32'h5555_5555;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    check_eq("pre_rst_dbg_addr", {27'h0, dbg_addr}, 32'd5);
    rst = 1'b1;
    #0;
    check_eq("in_rst_cmd_ready", {31'h0, bus.cmd_ready}, 32'd0);
    tick();
    check_eq("mid_rst_dbg_addr", {27'h0, dbg_addr}, 32'd0);
    check_eq("mid_rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'd0);
    rst = 1'b0;
    #1;
    check_eq("after_rst_cmd_ready", {31'h0, bus.cmd_ready}, 32'd1);
    cpu_halted = 1'b1;
    seen_valid = 0;
    seen_we    = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.rsp_valid) seen_valid++;
      if (dbg_we) seen_we++;
    end
    check_eq("after_rst_no_rsp", 32'(seen_valid), 32'd0);
    check_eq("after_rst_no_we", 32'(seen_we), 32'd0);
    do_cmd("rd_x5_after_rst", 1'b0, 5'd5, 32'h0, 1'b1, 0, 0, 32'hDEAD_BEEF, 2'b00, 3, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
